// File: rtl/lsu_mem_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_if
//
// Load/store unit that sits directly after the execute stage. It turns the
// per-cycle memory strobes from execute into a single req/ack transaction on
// a variable-latency data-memory bus. It stalls the pipeline while a
// transaction is outstanding and returns load data to the register file as
// a one-cycle write pulse. A sticky error flag reports bus timeouts and
// illegal operation encodings.
//
// Parameters
//   TIMEOUT  cycles bus_req may wait for bus_ack before giving up (0 = never)
//   CNT_W    wait counter width, must satisfy 2**CNT_W > TIMEOUT
//
// Ports
//   clk             rising-edge clock for all logic
//   reset           synchronous active-high reset, highest priority
//   d_mem_en        memory op strobe from execute
//   d_mem_rd        load request
//   d_mem_wr        store request
//   d_mem_addr      byte address of the op
//   d_mem_data_out  store data from execute
//   ld_dst_reg      destination register for a load
//   lsu_busy        stall to fetch/decode/execute (registered state decode)
//   ld_wr_en        one-cycle register write pulse for load data
//   ld_wr_sel       register index for the load write
//   ld_wr_data      load data, holds its value between pulses
//   bus_req         memory request, held until ack or timeout
//   bus_we          1 = write, 0 = read
//   bus_addr        latched address
//   bus_wdata       latched store data
//   bus_ack         memory completion, only looked at while requesting
//   bus_rdata       read data, valid with bus_ack
//   mem_err         sticky error flag
//   err_clr         clears mem_err (a new error in the same cycle wins)
// ---------------------------------------------------------------------------
module lsu_mem_if #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_mem_en,
    input  logic        d_mem_rd,
    input  logic        d_mem_wr,
    input  logic [11:0] d_mem_addr,
    input  logic [7:0]  d_mem_data_out,
    input  logic [2:0]  ld_dst_reg,
    output logic        lsu_busy,
    output logic        ld_wr_en,
    output logic [2:0]  ld_wr_sel,
    output logic [7:0]  ld_wr_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [11:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        mem_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic [2:0]       dst_q;

    logic op_legal;
    logic op_illegal;
    logic store_done;
    logic timeout_hit;
    logic accept_slot;

    // Decode of the incoming op and of the edges on which the unit is
    // (or is about to be) idle. A new op may be taken on any edge where the
    // state would otherwise land in IDLE, so back-to-back ops see no gap.
    // The wait counter saturates instead of wrapping so a disabled timeout
    // can never alias back to zero.
    always_comb begin
        op_legal     = d_mem_en & (d_mem_rd ^ d_mem_wr);
        op_illegal   = d_mem_en & ~(d_mem_rd ^ d_mem_wr);
        wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + CNT_W'(1);
        store_done   = (state == REQ) && bus_ack && bus_we;
        timeout_hit  = TIMEOUT_EN && (state == REQ) && !bus_ack
                       && (wait_cnt_inc >= TIMEOUT_V);
        accept_slot  = (state == IDLE) || (state == WB)
                       || store_done || timeout_hit;
    end

    // Main FSM with all outputs registered. The per-state case handles the
    // transaction in flight; the accept block afterwards overrides the next
    // state when a new legal op arrives in an accept slot. mem_err is set by
    // an illegal op or a timeout and only cleared when neither happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            dst_q      <= '0;
            lsu_busy   <= 1'b0;
            ld_wr_en   <= 1'b0;
            ld_wr_sel  <= '0;
            ld_wr_data <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            mem_err    <= 1'b0;
        end else begin
            ld_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    lsu_busy <= 1'b0;
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_we) begin
                            state    <= IDLE;
                            lsu_busy <= 1'b0;
                        end else begin
                            ld_wr_data <= bus_rdata;
                            ld_wr_sel  <= dst_q;
                            ld_wr_en   <= 1'b1;
                            state      <= WB;
                        end
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (timeout_hit) begin
                            bus_req  <= 1'b0;
                            state    <= IDLE;
                            lsu_busy <= 1'b0;
                        end
                    end
                end
                WB: begin
                    state    <= IDLE;
                    lsu_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    lsu_busy <= 1'b0;
                    bus_req  <= 1'b0;
                end
            endcase

            if (accept_slot && op_legal) begin
                state     <= REQ;
                lsu_busy  <= 1'b1;
                bus_req   <= 1'b1;
                bus_we    <= d_mem_wr;
                bus_addr  <= d_mem_addr;
                bus_wdata <= d_mem_data_out;
                dst_q     <= ld_dst_reg;
                wait_cnt  <= '0;
            end

            if ((accept_slot && op_illegal) || timeout_hit) begin
                mem_err <= 1'b1;
            end else if (err_clr) begin
                mem_err <= 1'b0;
            end
        end
    end

endmodule
